// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per req/ack transaction
// and issues it downstream over valid/ready, then steers the PC from the decoder's pc_control.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [2:0]  pc_control,
  input  logic [31:0] jr_target,
  output logic [31:0] retired,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        fetch_done;
  logic        issue_done;

  function automatic logic [31:0] calc_next_pc(
    input logic [2:0]  ctl,
    input logic [31:0] ipc,
    input logic [31:0] ins,
    input logic [31:0] jr
  );
    logic        [31:0] seq;
    logic signed [31:0] br_off;
    seq    = ipc + 32'd4;
    br_off = {{14{ins[15]}}, ins[15:0], 2'b00};
    case (ctl)
      3'b001:  calc_next_pc = {seq[31:28], ins[25:0], 2'b00};
      3'b010:  calc_next_pc = {jr[31:2], 2'b00};
      3'b011:  calc_next_pc = seq + $unsigned(br_off);
      default: calc_next_pc = seq;
    endcase
  endfunction

  assign fetch_done = (state == FETCH) && imem_ack;
  assign issue_done = (state == ISSUE) && instr_ready;
  assign next_pc    = calc_next_pc(pc_control, instr_pc, instr, jr_target);
  assign imem_addr  = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack)    state_nxt = ISSUE;
      ISSUE:   if (instr_ready) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and valid decode straight from state, so they are mutually exclusive
  // and drop the instant reset asserts.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req    = 1'b1;
      ISSUE:   instr_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      instr    <= 32'h0;
      instr_pc <= 32'h0;
      retired  <= 32'h0;
      misalign <= 1'b0;
    end else begin
      if (fetch_done) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (issue_done) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
        if (pc_control == 3'b010 && jr_target[1:0] != 2'b00)
          misalign <= 1'b1;
      end
    end
  end

endmodule
